axi4_lite_sram_bridge: RTL and testbench

AXI4-Lite slave front end that converts bus transactions into the single-port SRAM-style register interface (ADDR, W_DATA, WEN, R_DATA) of the register-file stage directly downstream. It serialises reads and writes onto the one port and performs read-modify-write for partial byte strobes. It generates OKAY/SLVERR responses, with SLVERR for out-of-range addresses.

---
 rtl/axi4_lite_pkg.sv | 27 ++
 rtl/axi4_lite_sram_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_lite_sram_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite to single-port register-file bridge.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RMW_RD,
    ST_WRITE,
    ST_WRESP,
    ST_RD_WAIT,
    ST_RRESP
  } state_e;

  // Byte-wise merge: a set strobe bit takes the new byte, otherwise the old byte survives.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_data,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_sram_bridge.sv
// AXI4-Lite slave that serialises reads, full writes and read-modify-write
// partial writes onto the single ADDR/W_DATA/WEN/R_DATA register-file port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accepting AW/W into holding regs, or AR when no write pending
// ST_RMW_RD  | ADDR driven, old word sampled from R_DATA for byte merge
// ST_WRITE   | WEN pulse with ADDR/W_DATA
// ST_WRESP   | BVALID held until BREADY
// ST_RD_WAIT | ADDR driven, R_DATA sampled into RDATA
// ST_RRESP   | RVALID held until RREADY
module axi4_lite_sram_bridge
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 16,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [REG_ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0]     W_DATA,
  output logic                      WEN,
  input  logic [DATA_WIDTH-1:0]     R_DATA
);

  localparam int WORD_W = AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

  state_e state_q, state_d;

  logic                      aw_cap_q, aw_cap_d;
  logic                      w_cap_q, w_cap_d;
  logic [WORD_W-1:0]         awword_q, awword_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rd_err_q, rd_err_d;

  logic                  idle, aw_ready, w_ready, ar_ready;
  logic                  aw_hs, w_hs, ar_hs, wr_go;
  logic [WORD_W-1:0]     wr_word, rd_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by RST so the bus sees them low while reset is held.
  assign idle     = (state_q == ST_IDLE) && !RST;
  assign aw_ready = idle && !aw_cap_q;
  assign w_ready  = idle && !w_cap_q;
  assign aw_hs    = S_AXI_AWVALID && aw_ready;
  assign w_hs     = S_AXI_WVALID && w_ready;
  assign ar_ready = idle && !aw_cap_q && !w_cap_q && !aw_hs && !w_hs;
  assign ar_hs    = S_AXI_ARVALID && ar_ready;

  // The write can be dispatched in the same cycle the second half arrives.
  assign wr_go       = idle && (aw_cap_q || aw_hs) && (w_cap_q || w_hs);
  assign wr_word     = aw_cap_q ? awword_q : S_AXI_AWADDR[AXI_ADDR_WIDTH-1:2];
  assign wr_data     = w_cap_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb     = w_cap_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_in_range = wr_word < NUM_REGS_W;
  assign rd_word     = S_AXI_ARADDR[AXI_ADDR_WIDTH-1:2];
  assign rd_in_range = rd_word < NUM_REGS_W;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      aw_cap_q <= 1'b0;
      w_cap_q  <= 1'b0;
      awword_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      addr_q   <= '0;
      w_data_q <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      aw_cap_q <= aw_cap_d;
      w_cap_q  <= w_cap_d;
      awword_q <= awword_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_go) begin
          if (!wr_in_range)         state_d = ST_WRESP;
          else if (wr_strb == '1)   state_d = ST_WRITE;
          else if (wr_strb == '0)   state_d = ST_WRESP;
          else                      state_d = ST_RMW_RD;
        end else if (ar_hs) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RMW_RD:  state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_WRESP;
      ST_WRESP:   if (S_AXI_BREADY) state_d = ST_IDLE;
      ST_RD_WAIT: state_d = ST_RRESP;
      ST_RRESP:   if (S_AXI_RREADY) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    aw_cap_d = aw_cap_q;
    w_cap_d  = w_cap_q;
    awword_d = awword_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    w_data_d = w_data_q;
    bresp_d  = bresp_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_err_d = rd_err_q;

    if (aw_hs) begin
      aw_cap_d = 1'b1;
      awword_d = S_AXI_AWADDR[AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_cap_d = 1'b1;
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_go) begin
          bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          if (wr_in_range && (wr_strb != '0)) addr_d = wr_word[REG_ADDR_WIDTH-1:0];
          if (wr_strb == '1) w_data_d = wr_data;
        end else if (ar_hs) begin
          addr_d   = rd_word[REG_ADDR_WIDTH-1:0];
          rd_err_d = !rd_in_range;
        end
      end
      ST_RMW_RD: w_data_d = strb_merge(R_DATA, wdata_q, wstrb_q);
      ST_WRESP: begin
        if (S_AXI_BREADY) begin
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        rdata_d = rd_err_q ? '0 : R_DATA;
        rresp_d = rd_err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_BVALID  = (state_q == ST_WRESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (state_q == ST_RRESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ADDR          = addr_q;
  assign W_DATA        = w_data_q;
  assign WEN           = (state_q == ST_WRITE);

endmodule

// File: tb/tb_axi4_lite_sram_bridge.sv
// Scoreboard bench for axi4_lite_sram_bridge: drivers push expected register-file
// writes and B/R responses; a negedge monitor pops and compares them.
module tb_axi4_lite_sram_bridge;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct { logic [3:0] idx; logic [31:0] data; int cyc; } wen_t;
  typedef struct { logic [1:0] resp; int cyc; } b_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; int cyc; } r_t;

  logic        clk;
  logic        RST;
  logic [11:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [11:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [3:0]  ADDR;
  logic [31:0] W_DATA;
  logic        WEN;
  logic [31:0] R_DATA;

  axi4_lite_sram_bridge dut (
    .CLK(clk), .RST(RST),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ADDR(ADDR), .W_DATA(W_DATA), .WEN(WEN), .R_DATA(R_DATA)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream register file: combinational read of the word on ADDR.
  logic [31:0] dut_mem [0:15];
  logic [31:0] ref_mem [0:15];
  logic        mem_load;
  assign R_DATA = dut_mem[ADDR];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) dut_mem[i] <= ref_mem[i];
    end else if (WEN) begin
      dut_mem[ADDR] <= W_DATA;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  wen_t exp_wen[$];
  b_t   exp_b[$];
  r_t   exp_r[$];
  int   b_done_cnt = 0;
  int   r_done_cnt = 0;
  int   b_done_cyc = 0;
  bit   b_seen = 0;
  bit   r_seen = 0;
  wen_t mw;
  b_t   mb;
  r_t   mr;

  always @(negedge clk) begin
    if (RST) begin
      exp_wen.delete();
      exp_b.delete();
      exp_r.delete();
      b_seen = 0;
      r_seen = 0;
    end else begin
      if (WEN) begin
        chk("wen_expected", exp_wen.size() != 0, 1);
        if (exp_wen.size() != 0) begin
          mw = exp_wen.pop_front();
          chk("wen_addr", ADDR, mw.idx);
          chk("wen_data", W_DATA, mw.data);
          chk("wen_cycle", cyc, mw.cyc);
        end
      end
      if (S_AXI_BVALID) begin
        chk("bvalid_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          mb = exp_b[0];
          chk("bresp", S_AXI_BRESP, mb.resp);
          if (!b_seen) chk("bvalid_cycle", cyc, mb.cyc);
          b_seen = 1;
          if (S_AXI_BREADY) begin
            void'(exp_b.pop_front());
            b_seen = 0;
            b_done_cyc = cyc;
            b_done_cnt++;
          end
        end
      end
      if (S_AXI_RVALID) begin
        chk("rvalid_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) begin
          mr = exp_r[0];
          chk("rdata", S_AXI_RDATA, mr.data);
          chk("rresp", S_AXI_RRESP, mr.resp);
          if (!r_seen) chk("rvalid_cycle", cyc, mr.cyc);
          r_seen = 1;
          if (S_AXI_RREADY) begin
            void'(exp_r.pop_front());
            r_seen = 0;
            r_done_cnt++;
          end
        end
      end
    end
  end

  // Response-channel readies: random, or held low for the first 5 valid cycles.
  bit stall_mode = 0;
  initial begin
    int bcnt, rcnt;
    bcnt = 0;
    rcnt = 0;
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt = S_AXI_BVALID ? bcnt + 1 : 0;
      rcnt = S_AXI_RVALID ? rcnt + 1 : 0;
      S_AXI_BREADY = stall_mode ? (bcnt > 5) : ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = stall_mode ? (rcnt > 5) : ($urandom_range(0, 3) != 0);
    end
  end

  // All driver tasks start and end at posedge + 1.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input bit track, output int hs);
    int aw_hs, w_hs, tgt, word, lat;
    bit ok_aw, ok_w, done;
    logic [31:0] merged;
    tgt = b_done_cnt + 1;
    aw_hs = 0;
    w_hs = 0;
    ok_aw = 0;
    ok_w = 0;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        S_AXI_AWADDR = addr;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (S_AXI_AWREADY) begin aw_hs = cyc; ok_aw = 1; break; end
        end
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (S_AXI_WREADY) begin w_hs = cyc; ok_w = 1; break; end
        end
        @(posedge clk); #1;
        S_AXI_WVALID = 1'b0;
      end
    join
    if (!ok_aw) fail_now("aw_handshake");
    if (!ok_w) fail_now("w_handshake");
    hs = (aw_hs > w_hs) ? aw_hs : w_hs;
    if (track) begin
      word = int'(addr[11:2]);
      if (word >= 16) begin
        exp_b.push_back('{SLVERR, hs + 1});
      end else if (strb == 4'h0) begin
        exp_b.push_back('{OKAY, hs + 1});
      end else begin
        merged = ref_mem[word];
        for (int b = 0; b < 4; b++)
          if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
        ref_mem[word] = merged;
        lat = (strb == 4'hF) ? 1 : 2;
        exp_wen.push_back('{word[3:0], merged, hs + lat});
        exp_b.push_back('{OKAY, hs + lat + 1});
      end
      done = 0;
      for (int i = 0; i < 100; i++) begin
        if (b_done_cnt >= tgt) begin done = 1; break; end
        @(negedge clk);
      end
      if (!done) fail_now("b_complete");
      @(posedge clk); #1;
    end
  endtask

  task automatic do_read(input logic [11:0] addr, output int hs);
    int tgt, word;
    bit ok, done;
    tgt = r_done_cnt + 1;
    ok = 0;
    hs = 0;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (S_AXI_ARREADY) begin hs = cyc; ok = 1; break; end
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    if (!ok) fail_now("ar_handshake");
    word = int'(addr[11:2]);
    if (word >= 16) exp_r.push_back('{32'h0, SLVERR, hs + 2});
    else            exp_r.push_back('{ref_mem[word], OKAY, hs + 2});
    done = 0;
    for (int i = 0; i < 100; i++) begin
      if (r_done_cnt >= tgt) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) fail_now("r_complete");
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2;
    logic [11:0] a;
    logic [3:0]  s;
    RST = 1'b1;
    mem_load = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'h11223344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_wdata", W_DATA, 0);
    chk("rst_wen", WEN, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    mem_load = 1'b0;
    @(posedge clk); #1;

    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 1, h);
    do_write(12'h00C, 32'hAABBCCDD, 4'b0101, 0, 0, 1, h);
    do_read(12'h00C, h);

    fork
      do_write(12'h00C, 32'h5A5AC3C3, 4'hF, 3, 0, 1, h1);
      begin
        @(posedge clk); #1;
        do_read(12'h00C, h2);
      end
    join
    chk("ar_after_write", h2, b_done_cyc + 1);

    do_write(12'h040, 32'h12345678, 4'hF, 0, 0, 1, h);
    do_read(12'h040, h);
    do_write(12'h004, 32'hCAFEF00D, 4'h0, 1, 0, 1, h);

    stall_mode = 1;
    do_write(12'h010, 32'h0BADC0DE, 4'hF, 0, 0, 1, h);
    do_read(12'h010, h);
    stall_mode = 0;

    do_write(12'h014, 32'hFFFFFFFF, 4'b0011, 0, 0, 0, h);
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    @(negedge clk);
    chk("midrst_wen", WEN, 0);
    chk("midrst_bvalid", S_AXI_BVALID, 0);
    chk("midrst_rvalid", S_AXI_RVALID, 0);
    chk("midrst_addr", ADDR, 0);
    chk("midrst_wdata", W_DATA, 0);
    chk("midrst_rdata", S_AXI_RDATA, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_wen", WEN, 0);
      chk("midrst_no_bvalid", S_AXI_BVALID, 0);
    end
    @(posedge clk); #1;
    do_read(12'h014, h);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) a = 12'($urandom);
      else                           a = 12'($urandom_range(0, 79));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0:       s = 4'h0;
          1, 2:    s = 4'hF;
          default: s = 4'($urandom);
        endcase
        do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), 1, h);
      end else begin
        do_read(a, h);
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wen_queue_drained", exp_wen.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    chk("r_queue_drained", exp_r.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
